// File: rtl/router_sync_multi.sv
// Router synchroniser for NUM_CH destination FIFOs: address latch, write steering, and per-channel read timeout.
// Optional macro SYNC_TIMEOUT_STATS_EN adds an 8-bit saturating soft-reset event counter (timeout_events).
module router_sync_multi #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
`ifdef SYNC_TIMEOUT_STATS_EN
  ,
  output logic [7:0]        timeout_events
`endif
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]  NUM_CH_A = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_err_q, addr_err_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] soft_reset_q, soft_reset_d;
  logic [NUM_CH-1:0] counting_s;

  // Address and error flag: capture on the header strobe, otherwise hold.
  always_comb begin
    addr_d     = addr_q;
    addr_err_d = addr_err_q;
    if (detect_add) begin
      addr_d     = data_in;
      addr_err_d = ({1'b0, data_in} >= NUM_CH_A);
    end else begin
      addr_d     = addr_q;
      addr_err_d = addr_err_q;
    end
  end

  // Address state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Steering: an invalid address drains the packet with no write and no stall.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!addr_err_q && (addr_q == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end else begin
        write_enb[i] = 1'b0;
      end
    end
  end

  // Per-channel timeout FSM, next state: COUNTING while valid and unread, else IDLE.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]        = '0;
      soft_reset_d[i] = 1'b0;
      if (counting_s[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i]        = '0;
          soft_reset_d[i] = 1'b1;
        end else begin
          cnt_d[i]        = cnt_q[i] + CNT_W'(1);
          soft_reset_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i]        = '0;
        soft_reset_d[i] = 1'b0;
      end
    end
  end

  // Per-channel timeout state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      soft_reset_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      soft_reset_q <= soft_reset_d;
    end
  end

  // Output decode.
  always_comb begin
    vld_out    = ~empty;
    counting_s = ~empty & ~read_enb;
    soft_reset = soft_reset_q;
    addr_err   = addr_err_q;
  end

`ifdef SYNC_TIMEOUT_STATS_EN
  logic [7:0] events_q, events_d;

  function automatic logic [4:0] popcount(input logic [NUM_CH-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < NUM_CH; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  // Saturating sum of pulses seen each cycle.
  always_comb begin
    logic [8:0] sum_s;
    sum_s = {1'b0, events_q} + {4'd0, popcount(soft_reset_q)};
    if (sum_s > 9'd255) begin
      events_d = 8'd255;
    end else begin
      events_d = sum_s[7:0];
    end
  end

  // Event counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      events_q <= 8'd0;
    end else begin
      events_q <= events_d;
    end
  end

  assign timeout_events = events_q;
`endif

endmodule
